fnd_scan_controller: RTL and testbench

- Downstream consumer of the stopwatch/watch datapath outputs (msec, sec, min, hour).
- Time-multiplexes a 4-digit common-anode 7-segment display, selecting the sec:msec or hour:min pair with sel_display.
- Blinks the colon decimal point at 1 Hz and blinks the digit pair under edit while in edit mode.
- Outputs drive the board FND pins directly.

---
 rtl/fnd_scan_if.sv | 54 +++++
 rtl/fnd_scan_controller.sv | 213 +++++++++++++++++++++
 tb/tb_fnd_scan_controller.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fnd_scan_if.sv
// ----------------------------------------------------------------------------
// fnd_scan_if
//   Bundles the time values and display controls going into the FND scan
//   controller together with the digit-enable / segment pins it drives.
//
//   Signals:
//     msec        [6:0]  hundredths of a second, 0..99
//     sec         [5:0]  seconds, 0..59
//     min         [5:0]  minutes, 0..59
//     hour        [4:0]  hours, 0..23
//     sel_display        1: hour:min pair, 0: sec:msec pair
//     edit_en            time-set mode, the selected pair blinks
//     edit_sel           0: right pair (digits 0-1), 1: left pair (digits 2-3)
//     fnd_com     [3:0]  digit enables, active-low one-hot, bit0 = rightmost
//     fnd_data    [7:0]  segments {dp,g,f,e,d,c,b,a}, active-low
//
//   master: the side that produces time values and watches the pins.
//   slave : the scan controller.
// ----------------------------------------------------------------------------
interface fnd_scan_if;
    logic [6:0] msec;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic       sel_display;
    logic       edit_en;
    logic       edit_sel;
    logic [3:0] fnd_com;
    logic [7:0] fnd_data;

    modport master (
        output msec,
        output sec,
        output min,
        output hour,
        output sel_display,
        output edit_en,
        output edit_sel,
        input  fnd_com,
        input  fnd_data
    );

    modport slave (
        input  msec,
        input  sec,
        input  min,
        input  hour,
        input  sel_display,
        input  edit_en,
        input  edit_sel,
        output fnd_com,
        output fnd_data
    );
endinterface

// File: rtl/fnd_scan_controller.sv
// ----------------------------------------------------------------------------
// fnd_scan_controller
//   Time-multiplexes a 4-digit common-anode 7-segment display. One digit is
//   enabled per scan tick; the four digit values of a frame are taken from a
//   snapshot of the inputs captured when the scan wraps from digit 3 back to
//   digit 0, so a frame never mixes old and new values. The colon dp (digit 2)
//   is lit while msec < 50, and in edit mode the chosen digit pair is blanked
//   during the off half of a free-running blink phase.
//
//   Ports:
//     clk    system clock
//     reset  asynchronous, active-low reset
//     bus    fnd_scan_if.slave: time values / display controls in,
//            fnd_com / fnd_data out (both registered)
//
//   Parameters:
//     CLK_FREQ  system clock frequency in Hz
//     SCAN_HZ   digit-advance rate in Hz (frame rate is SCAN_HZ/4)
//     BLINK_HZ  edit-blink rate; phase toggles every CLK_FREQ/(2*BLINK_HZ)
// ----------------------------------------------------------------------------
module fnd_scan_controller #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int SCAN_HZ  = 1000,
    parameter int BLINK_HZ = 2
) (
    input  logic      clk,
    input  logic      reset,
    fnd_scan_if.slave bus
);

    localparam int SCAN_DIV  = CLK_FREQ / SCAN_HZ;
    localparam int BLINK_DIV = CLK_FREQ / (2 * BLINK_HZ);
    localparam int SCAN_W    = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic [7:0] seg_encode(input logic [6:0] d);
        logic [7:0] s;
        case (d)
            7'd0:    s = 8'hC0;
            7'd1:    s = 8'hF9;
            7'd2:    s = 8'hA4;
            7'd3:    s = 8'hB0;
            7'd4:    s = 8'h99;
            7'd5:    s = 8'h92;
            7'd6:    s = 8'h82;
            7'd7:    s = 8'hF8;
            7'd8:    s = 8'h80;
            7'd9:    s = 8'h90;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    // Largest legal value of the pair feeding the given side of the display.
    function automatic logic [6:0] pair_limit(input logic left, input logic hour_min);
        logic [6:0] lim;
        if (left) begin
            lim = hour_min ? 7'd23 : 7'd59;
        end else begin
            lim = hour_min ? 7'd59 : 7'd99;
        end
        return lim;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SCAN_W-1:0]  scan_cnt_q,  scan_cnt_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_on_q,  blink_on_d;
    logic [1:0]         idx_q,       idx_d;

    logic [6:0]         msec_q,      msec_d;
    logic [5:0]         sec_q,       sec_d;
    logic [5:0]         min_q,       min_d;
    logic [4:0]         hour_q,      hour_d;
    logic               sel_q,       sel_d;
    logic               edit_en_q,   edit_en_d;
    logic               edit_sel_q,  edit_sel_d;

    logic [3:0]         com_q,       com_d;
    logic [7:0]         data_q,      data_d;

    logic               scan_tick;
    logic               blink_toggle;
    logic               frame_wrap;
    logic               left_pair;
    logic [6:0]         pair_val;
    logic [6:0]         digit_val;
    logic [7:0]         seg;

    // ------------------------------------------------------------------
    // Scan and blink timing
    // ------------------------------------------------------------------
    always_comb begin
        scan_tick    = (scan_cnt_q == SCAN_LAST);
        scan_cnt_d   = scan_tick ? '0 : scan_cnt_q + SCAN_W'(1);

        // The blink phase runs free so entering edit mode needs no restart.
        blink_toggle = (blink_cnt_q == BLINK_LAST);
        blink_cnt_d  = blink_toggle ? '0 : blink_cnt_q + BLINK_W'(1);
        blink_on_d   = blink_toggle ? ~blink_on_q : blink_on_q;

        idx_d        = scan_tick ? idx_q + 2'd1 : idx_q;
        frame_wrap   = scan_tick && (idx_q == 2'd3);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_cnt_q  <= '0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            idx_q       <= 2'd0;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            idx_q       <= idx_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame snapshot: taken on the tick that displays digit 3 and wraps
    // the index, so the next four digits all come from this one capture.
    // ------------------------------------------------------------------
    always_comb begin
        msec_d     = frame_wrap ? bus.msec        : msec_q;
        sec_d      = frame_wrap ? bus.sec         : sec_q;
        min_d      = frame_wrap ? bus.min         : min_q;
        hour_d     = frame_wrap ? bus.hour        : hour_q;
        sel_d      = frame_wrap ? bus.sel_display : sel_q;
        edit_en_d  = frame_wrap ? bus.edit_en     : edit_en_q;
        edit_sel_d = frame_wrap ? bus.edit_sel    : edit_sel_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            msec_q     <= '0;
            sec_q      <= '0;
            min_q      <= '0;
            hour_q     <= '0;
            sel_q      <= 1'b0;
            edit_en_q  <= 1'b0;
            edit_sel_q <= 1'b0;
        end else begin
            msec_q     <= msec_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            sel_q      <= sel_d;
            edit_en_q  <= edit_en_d;
            edit_sel_q <= edit_sel_d;
        end
    end

    // ------------------------------------------------------------------
    // Digit decode for the digit currently indexed. The enable and the
    // segment code are both derived from idx_q and loaded on the same
    // tick, so the pins can never show one digit's data on another.
    // ------------------------------------------------------------------
    always_comb begin
        left_pair = idx_q[1];

        if (left_pair) begin
            pair_val = sel_q ? {2'b00, hour_q} : {1'b0, sec_q};
        end else begin
            pair_val = sel_q ? {1'b0, min_q} : msec_q;
        end

        digit_val = idx_q[0] ? (pair_val / 7'd10) : (pair_val % 7'd10);
        seg       = seg_encode(digit_val);

        // Colon dp tracks the half-second of msec in both display modes.
        if ((idx_q == 2'd2) && (msec_q < 7'd50)) begin
            seg[7] = 1'b0;
        end

        if (pair_val > pair_limit(left_pair, sel_q)) begin
            seg = SEG_DASH;
        end

        // Blanking wins over everything, dp included.
        if (edit_en_q && !blink_on_q && (edit_sel_q == left_pair)) begin
            seg = SEG_BLANK;
        end

        com_d  = scan_tick ? ~(4'b0001 << idx_q) : com_q;
        data_d = scan_tick ? seg : data_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            com_q  <= 4'b1111;
            data_q <= SEG_BLANK;
        end else begin
            com_q  <= com_d;
            data_q <= data_d;
        end
    end

    assign bus.fnd_com  = com_q;
    assign bus.fnd_data = data_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// ----------------------------------------------------------------------------
// tb_fnd_scan_controller
//   Bench for fnd_scan_controller with CLK_FREQ=1000, SCAN_HZ=100 (tick every
//   10 cycles) and BLINK_HZ=25 (blink phase toggles every 20 cycles).
//   A reference model derives the expected pins from the clock-edge count
//   since reset: edge 10*m shows digit (m-1)%4, a snapshot is taken when
//   digit 3 is shown, and the blink phase seen at edge e is off when
//   ((e-1)/20) is odd.
// ----------------------------------------------------------------------------
module tb_fnd_scan_controller;
    localparam int CLK_FREQ = 1000;
    localparam int SCAN_HZ  = 100;
    localparam int BLINK_HZ = 25;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    fnd_scan_if bus ();

    fnd_scan_controller #(
        .CLK_FREQ (CLK_FREQ),
        .SCAN_HZ  (SCAN_HZ),
        .BLINK_HZ (BLINK_HZ)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic logic [7:0] seg_of(int d);
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'hBF;
        endcase
    endfunction

    function automatic logic [7:0] model_seg(int digit, int ms, int s, int mi, int h,
                                             bit sel, bit en, bit es, bit phase_on);
        bit         left;
        int         v;
        int         lim;
        logic [7:0] code;
        left = (digit >= 2);
        if (en && !phase_on && (left == es)) return 8'hFF;
        v   = left ? (sel ? h : s) : (sel ? mi : ms);
        lim = left ? (sel ? 23 : 59) : (sel ? 59 : 99);
        if (v > lim) return 8'hBF;
        code = seg_of((digit % 2 == 0) ? (v % 10) : (v / 10));
        if (digit == 2 && ms < 50) code[7] = 1'b0;
        return code;
    endfunction

    // Digit shown at the edge following edge count e (ticks at edges 10,20,...).
    function automatic int tick_digit(int e);
        return ((e + 1) / 10 - 1) % 4;
    endfunction

    int         e_m    = 0;
    int         sh_ms  = 0;
    int         sh_s   = 0;
    int         sh_mi  = 0;
    int         sh_h   = 0;
    bit         sh_sel = 1'b0;
    bit         sh_en  = 1'b0;
    bit         sh_es  = 1'b0;
    logic [3:0] exp_com  = 4'hF;
    logic [7:0] exp_data = 8'hFF;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_m      <= 0;
            sh_ms    <= 0;
            sh_s     <= 0;
            sh_mi    <= 0;
            sh_h     <= 0;
            sh_sel   <= 1'b0;
            sh_en    <= 1'b0;
            sh_es    <= 1'b0;
            exp_com  <= 4'hF;
            exp_data <= 8'hFF;
        end else begin
            e_m <= e_m + 1;
            if ((e_m + 1) % 10 == 0) begin
                exp_com  <= ~(4'b0001 << tick_digit(e_m));
                exp_data <= model_seg(tick_digit(e_m), sh_ms, sh_s, sh_mi, sh_h,
                                      sh_sel, sh_en, sh_es, (e_m / 20) % 2 == 0);
                if (tick_digit(e_m) == 3) begin
                    sh_ms  <= int'(bus.msec);
                    sh_s   <= int'(bus.sec);
                    sh_mi  <= int'(bus.min);
                    sh_h   <= int'(bus.hour);
                    sh_sel <= bus.sel_display;
                    sh_en  <= bus.edit_en;
                    sh_es  <= bus.edit_sel;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (no checking)
    // ------------------------------------------------------------------
    task automatic set_inputs(int ms, int s, int mi, int h, bit sel, bit en, bit es);
        bus.msec        = 7'(ms);
        bus.sec         = 6'(s);
        bus.min         = 6'(mi);
        bus.hour        = 5'(h);
        bus.sel_display = sel;
        bus.edit_en     = en;
        bus.edit_sel    = es;
    endtask

    // Called at a negedge; releases at a negedge so the next posedge is edge 1.
    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        set_inputs(37, 42, 0, 0, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if (bus.fnd_com !== 4'b1111 || bus.fnd_data !== 8'hFF)
            $display("FAIL reset_async: com=%b data=%h, want com=1111 data=ff", bus.fnd_com, bus.fnd_data);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            n_total++;
            if (c < 10) begin
                if (bus.fnd_com !== 4'b1111 || bus.fnd_data !== 8'hFF)
                    $display("FAIL reset_idle c=%0d: com=%b data=%h, want com=1111 data=ff", c, bus.fnd_com, bus.fnd_data);
                else n_pass++;
            end else begin
                if (bus.fnd_com !== 4'b1110 || bus.fnd_data !== 8'hC0)
                    $display("FAIL reset_first_tick: com=%b data=%h, want com=1110 data=c0", bus.fnd_com, bus.fnd_data);
                else n_pass++;
            end
        end
    endtask

    task automatic test_sec_msec();
        logic [7:0] want [4];
        want = '{8'hF8, 8'hB0, 8'h24, 8'h99};
        set_inputs(37, 42, 0, 0, 1'b0, 1'b0, 1'b0);
        pulse_reset();
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            n_total++;
            if (bus.fnd_com !== exp_com || bus.fnd_data !== exp_data)
                $display("FAIL sec_msec_model c=%0d: com=%b data=%h, want com=%b data=%h", c, bus.fnd_com, bus.fnd_data, exp_com, exp_data);
            else n_pass++;
            if (c >= 50 && c % 10 == 0) begin
                n_total++;
                if (bus.fnd_com !== ~(4'b0001 << (c / 10 - 5)) || bus.fnd_data !== want[c / 10 - 5])
                    $display("FAIL sec_msec_digit%0d: com=%b data=%h, want data=%h", c / 10 - 5, bus.fnd_com, bus.fnd_data, want[c / 10 - 5]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_hour_min();
        logic [7:0] want [4];
        want = '{8'h92, 8'hC0, 8'h10, 8'hC0};
        set_inputs(20, 42, 5, 9, 1'b1, 1'b0, 1'b0);
        pulse_reset();
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            n_total++;
            if (bus.fnd_com !== exp_com || bus.fnd_data !== exp_data)
                $display("FAIL hour_min_model c=%0d: com=%b data=%h, want com=%b data=%h", c, bus.fnd_com, bus.fnd_data, exp_com, exp_data);
            else n_pass++;
            if (c >= 50 && c % 10 == 0) begin
                n_total++;
                if (bus.fnd_com !== ~(4'b0001 << (c / 10 - 5)) || bus.fnd_data !== want[c / 10 - 5])
                    $display("FAIL hour_min_digit%0d: com=%b data=%h, want data=%h", c / 10 - 5, bus.fnd_com, bus.fnd_data, want[c / 10 - 5]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_no_tearing();
        logic [7:0] want;
        set_inputs(37, 42, 0, 0, 1'b0, 1'b0, 1'b0);
        pulse_reset();
        for (int c = 1; c <= 120; c++) begin
            @(negedge clk);
            n_total++;
            if (bus.fnd_com !== exp_com || bus.fnd_data !== exp_data)
                $display("FAIL tear_model c=%0d: com=%b data=%h, want com=%b data=%h", c, bus.fnd_com, bus.fnd_data, exp_com, exp_data);
            else n_pass++;
            if (c == 70 || c == 80 || c == 110 || c == 120) begin
                case (c)
                    70:      want = 8'h24;
                    80:      want = 8'h99;
                    110:     want = 8'h30;
                    default: want = 8'h99;
                endcase
                n_total++;
                if (bus.fnd_data !== want)
                    $display("FAIL tear_c%0d: data=%h, want %h", c, bus.fnd_data, want);
                else n_pass++;
            end
            // Digit 0 of frame 2 is on the pins and the index has moved to 1.
            if (c == 50) bus.sec = 6'd43;
        end
    endtask

    task automatic test_edit_blink();
        logic [7:0] norm [4];
        logic [7:0] want;
        int         d;
        norm = '{8'hF8, 8'hB0, 8'h24, 8'h99};
        set_inputs(37, 42, 0, 0, 1'b0, 1'b1, 1'b1);
        pulse_reset();
        for (int c = 1; c <= 160; c++) begin
            @(negedge clk);
            n_total++;
            if (bus.fnd_com !== exp_com || bus.fnd_data !== exp_data)
                $display("FAIL edit_left_model c=%0d: com=%b data=%h, want com=%b data=%h", c, bus.fnd_com, bus.fnd_data, exp_com, exp_data);
            else n_pass++;
            if (c >= 50 && c % 10 == 0) begin
                d = (c / 10 - 1) % 4;
                // Frame and blink periods are both 40 cycles: the left pair
                // always lands in the off phase, the right pair in the on phase.
                want = (d >= 2) ? 8'hFF : norm[d];
                n_total++;
                if (bus.fnd_data !== want)
                    $display("FAIL edit_left_c%0d: data=%h, want %h", c, bus.fnd_data, want);
                else n_pass++;
            end
        end
        set_inputs(37, 42, 0, 0, 1'b0, 1'b1, 1'b0);
        pulse_reset();
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            n_total++;
            if (bus.fnd_com !== exp_com || bus.fnd_data !== exp_data)
                $display("FAIL edit_right_model c=%0d: com=%b data=%h, want com=%b data=%h", c, bus.fnd_com, bus.fnd_data, exp_com, exp_data);
            else n_pass++;
            if (c == 70) begin
                n_total++;
                if (bus.fnd_data !== 8'h24)
                    $display("FAIL edit_right_left_steady: data=%h, want 24", bus.fnd_data);
                else n_pass++;
            end
        end
    endtask

    task automatic test_range();
        logic [7:0] want [4];
        want = '{8'hF8, 8'hB0, 8'hBF, 8'hBF};
        set_inputs(37, 60, 0, 0, 1'b0, 1'b0, 1'b0);
        pulse_reset();
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            n_total++;
            if (bus.fnd_com !== exp_com || bus.fnd_data !== exp_data)
                $display("FAIL range_model c=%0d: com=%b data=%h, want com=%b data=%h", c, bus.fnd_com, bus.fnd_data, exp_com, exp_data);
            else n_pass++;
            if (c >= 50 && c % 10 == 0) begin
                n_total++;
                if (bus.fnd_data !== want[c / 10 - 5])
                    $display("FAIL range_digit%0d: data=%h, want %h", c / 10 - 5, bus.fnd_data, want[c / 10 - 5]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        set_inputs(0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        pulse_reset();
        for (int c = 1; c <= 1600; c++) begin
            @(negedge clk);
            n_total++;
            if (bus.fnd_com !== exp_com || bus.fnd_data !== exp_data)
                $display("FAIL random_model c=%0d: com=%b data=%h, want com=%b data=%h", c, bus.fnd_com, bus.fnd_data, exp_com, exp_data);
            else n_pass++;
            if ($urandom_range(0, 14) == 0)
                set_inputs(int'($urandom_range(0, 110)), int'($urandom_range(0, 63)),
                           int'($urandom_range(0, 63)), int'($urandom_range(0, 28)),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid_frame();
        bit found;
        set_inputs(88, 17, 33, 21, 1'b0, 1'b0, 1'b0);
        pulse_reset();
        found = 1'b0;
        for (int c = 0; c < 80 && !found; c++) begin
            @(negedge clk);
            if (bus.fnd_com === 4'b1011) found = 1'b1;
        end
        n_total++;
        if (!found) $display("FAIL midreset_wait: com=%b, want 1011 within 80 cycles", bus.fnd_com);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if (bus.fnd_com !== 4'b1111 || bus.fnd_data !== 8'hFF)
            $display("FAIL midreset_async: com=%b data=%h, want com=1111 data=ff", bus.fnd_com, bus.fnd_data);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            n_total++;
            if (c < 10) begin
                if (bus.fnd_com !== 4'b1111 || bus.fnd_data !== 8'hFF)
                    $display("FAIL midreset_idle c=%0d: com=%b data=%h, want com=1111 data=ff", c, bus.fnd_com, bus.fnd_data);
                else n_pass++;
            end else begin
                if (bus.fnd_com !== 4'b1110 || bus.fnd_data !== 8'hC0)
                    $display("FAIL midreset_first_tick: com=%b data=%h, want com=1110 data=c0", bus.fnd_com, bus.fnd_data);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_sec_msec();
        test_hour_min();
        test_no_tearing();
        test_edit_blink();
        test_range();
        test_random();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
